cipher_char_scheduler: RTL and testbench

Sits between the keyboard decode path (scan code to ASCII) and the cipher_vga character renderer. It captures each key press, applies a rotating Vigenère shift, and buffers the result in a small FIFO. It then issues one draw request at a time to the renderer with a cursor position, waiting for completion before the next. It replaces the free-running keyboard_clk toggle with a proper clk-domain handshake.

---
 rtl/cipher_char_scheduler_if.sv | 12 +
 rtl/cipher_char_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_cipher_char_scheduler.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cipher_char_scheduler_if.sv
// Draw request/complete handshake between the character scheduler and the
// character renderer.
interface cipher_char_scheduler_if;
  logic       draw_req;
  logic [7:0] draw_char;
  logic [5:0] draw_col;
  logic [4:0] draw_row;
  logic       draw_done;

  modport master (output draw_req, draw_char, draw_col, draw_row, input draw_done);
  modport slave  (input draw_req, draw_char, draw_col, draw_row, output draw_done);
endinterface

// File: rtl/cipher_char_scheduler.sv
// Captures key presses, applies a rotating Vigenere shift, buffers them in a
// FIFO and feeds the renderer one draw at a time while tracking the cursor.
module cipher_char_scheduler #(
  parameter int FIFO_DEPTH = 8,
  parameter int KEY_COUNT  = 4,
  parameter int COLS       = 40,
  parameter int ROWS       = 30
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           kb_ready,
  input  logic [7:0]                     kb_ascii,
  input  logic                           decrypt,
  input  logic                           key_wr,
  input  logic [$clog2(KEY_COUNT)-1:0]   key_addr,
  input  logic [4:0]                     key_val,
  cipher_char_scheduler_if.master        draw,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic                           overflow,
  output logic [$clog2(KEY_COUNT)-1:0]   cipher_idx
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int KW = $clog2(KEY_COUNT);

  typedef enum logic [1:0] {IDLE, LOAD, REQ, ADV} state_t;

  function automatic logic [4:0] key_init(input int i);
    case (i % 4)
      0:       return 5'd3;
      2:       return 5'd4;
      default: return 5'd1;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic          kb_q, kb_d, kb_prev_q, kb_prev_d;
  logic [7:0]    asc_q, asc_d;
  logic [4:0]    key_q [KEY_COUNT];
  logic [4:0]    key_d [KEY_COUNT];
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d, bs_q, bs_d;
  logic [KW-1:0] cidx_q, cidx_d;
  logic [7:0]    hold_q, hold_d, char_q, char_d;
  logic [5:0]    col_q, col_d;
  logic [4:0]    row_q, row_d;

  logic          is_up, is_lo, letter, rise, full, push, pop;
  logic [7:0]    base, enc;
  logic [4:0]    off, k, sh;
  logic [5:0]    s6;

  // Shift the registered key char; encrypt needs a 6-bit sum since off+k reaches 50.
  always_comb begin
    is_up  = (asc_q >= 8'h41) && (asc_q <= 8'h5A);
    is_lo  = (asc_q >= 8'h61) && (asc_q <= 8'h7A);
    letter = is_up | is_lo;
    base   = is_lo ? 8'h61 : 8'h41;
    off    = 5'(asc_q - base);
    k      = key_q[cidx_q];
    s6     = {1'b0, off} + {1'b0, k};
    if (decrypt) sh = (off >= k) ? off - k : off + 5'd26 - k;
    else         sh = (s6 >= 6'd26) ? 5'(s6 - 6'd26) : s6[4:0];
    enc    = letter ? base + {3'b000, sh} : asc_q;
  end

  always_comb begin
    kb_d      = kb_ready;
    kb_prev_d = kb_q;
    asc_d     = kb_ascii;
    key_d     = key_q;
    if (key_wr && key_val <= 5'd25) key_d[key_addr] = key_val;

    state_d = state_q;
    hold_d  = hold_q;
    bs_d    = bs_q;
    char_d  = char_q;
    col_d   = col_q;
    row_d   = row_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (count_q != '0) begin
        pop     = 1'b1;
        hold_d  = mem_q[rd_q];
        state_d = LOAD;
      end
      LOAD: begin
        if (hold_q == 8'h0D) begin
          col_d   = '0;
          row_d   = (row_q == 5'(ROWS-1)) ? '0 : row_q + 5'd1;
          state_d = IDLE;
        end else if (hold_q == 8'h08) begin
          if (col_q != '0) begin
            col_d   = col_q - 6'd1;
            char_d  = 8'h20;
            bs_d    = 1'b1;
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end else begin
          char_d  = hold_q;
          bs_d    = 1'b0;
          state_d = REQ;
        end
      end
      REQ: if (draw.draw_done) state_d = bs_q ? IDLE : ADV;
      ADV: begin
        if (col_q == 6'(COLS-1)) begin
          col_d = '0;
          row_d = (row_q == 5'(ROWS-1)) ? '0 : row_q + 5'd1;
        end else begin
          col_d = col_q + 6'd1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A full FIFO drops the candidate even if this cycle also pops.
    rise   = kb_q & ~kb_prev_q;
    full   = (count_q == LW'(FIFO_DEPTH));
    push   = rise & ~full;
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cidx_d = cidx_q;
    ovf_d  = ovf_q | (rise & full);
    if (push) begin
      mem_d[wr_q] = enc;
      wr_d        = wr_q + PW'(1);
      if (letter) cidx_d = cidx_q + KW'(1);
    end
    if (pop) rd_d = rd_q + PW'(1);
    count_d = count_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      kb_q      <= 1'b0;
      kb_prev_q <= 1'b0;
      asc_q     <= '0;
      for (int i = 0; i < KEY_COUNT; i++) key_q[i] <= key_init(i);
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      cidx_q    <= '0;
      hold_q    <= '0;
      bs_q      <= 1'b0;
      char_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
    end else begin
      state_q   <= state_d;
      kb_q      <= kb_d;
      kb_prev_q <= kb_prev_d;
      asc_q     <= asc_d;
      key_q     <= key_d;
      mem_q     <= mem_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      cidx_q    <= cidx_d;
      hold_q    <= hold_d;
      bs_q      <= bs_d;
      char_q    <= char_d;
      col_q     <= col_d;
      row_q     <= row_d;
    end
  end

  assign draw.draw_req  = (state_q == REQ);
  assign draw.draw_char = char_q;
  assign draw.draw_col  = col_q;
  assign draw.draw_row  = row_q;
  assign fifo_level     = count_q;
  assign overflow       = ovf_q;
  assign cipher_idx     = cidx_q;
endmodule

// File: tb/tb_cipher_char_scheduler.sv
// Randomised and directed checks of the cipher scheduler against a queue-based
// model of cipher, cursor and draw order.
module tb_cipher_char_scheduler;
  localparam int COLS = 40;
  localparam int ROWS = 30;

  logic       clk = 1'b0, resetn = 1'b0;
  logic       kb_ready = 1'b0, decrypt = 1'b0, key_wr = 1'b0;
  logic [7:0] kb_ascii = '0;
  logic [1:0] key_addr = '0;
  logic [4:0] key_val = '0;
  logic [3:0] fifo_level;
  logic       overflow;
  logic [1:0] cipher_idx;

  cipher_char_scheduler_if draw_if();

  cipher_char_scheduler dut (
    .clk(clk), .resetn(resetn), .kb_ready(kb_ready), .kb_ascii(kb_ascii),
    .decrypt(decrypt), .key_wr(key_wr), .key_addr(key_addr), .key_val(key_val),
    .draw(draw_if), .fifo_level(fifo_level), .overflow(overflow), .cipher_idx(cipher_idx)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int mk[4];
  int midx, mcol, mrow;
  typedef struct { logic [7:0] c; int col; int row; } exp_t;
  exp_t exp_q[$];

  function automatic bit is_letter(input int c);
    return (c >= 65 && c <= 90) || (c >= 97 && c <= 122);
  endfunction

  function automatic logic [7:0] cipher(input logic [7:0] c, input bit dec, input int k);
    int ci, base, off;
    ci   = c;
    base = (ci >= 97) ? 97 : 65;
    off  = ci - base;
    off  = dec ? (off - k + 26) % 26 : (off + k) % 26;
    return 8'(base + off);
  endfunction

  task automatic model_reset();
    mk = '{3, 1, 4, 1};
    midx = 0; mcol = 0; mrow = 0;
    exp_q.delete();
  endtask

  task automatic model_push(input logic [7:0] c, input bit dec, output bit draws);
    logic [7:0] v;
    exp_t e;
    v = c;
    draws = 1'b0;
    if (is_letter(int'(c))) begin
      v = cipher(c, dec, mk[midx]);
      midx = (midx + 1) % 4;
    end
    if (v == 8'h0D) begin
      mcol = 0; mrow = (mrow + 1) % ROWS;
    end else if (v == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        e = '{8'h20, mcol, mrow}; exp_q.push_back(e); draws = 1'b1;
      end
    end else begin
      e = '{v, mcol, mrow}; exp_q.push_back(e); draws = 1'b1;
      mcol++;
      if (mcol == COLS) begin mcol = 0; mrow = (mrow + 1) % ROWS; end
    end
  endtask

  task automatic type_char(input logic [7:0] c);
    @(negedge clk); kb_ascii = c; kb_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); kb_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_req();
    int t;
    t = 0;
    while (draw_if.draw_req !== 1'b1 && t < 60) begin @(negedge clk); t++; end
  endtask

  task automatic serve(input int exp_lvl);
    exp_t e;
    wait_req();
    n_vec++;
    if (draw_if.draw_req !== 1'b1) begin
      n_err++; $display("FAIL serve_timeout draw_req=%b want 1", draw_if.draw_req);
      return;
    end
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++; $display("FAIL unexpected_draw char=%h want none", draw_if.draw_char);
    end else begin
      e = exp_q.pop_front();
      if (draw_if.draw_char !== e.c) begin n_err++; $display("FAIL draw_char got=%h want=%h", draw_if.draw_char, e.c); end
      n_vec++;
      if (draw_if.draw_col !== 6'(e.col)) begin n_err++; $display("FAIL draw_col got=%0d want=%0d", draw_if.draw_col, e.col); end
      n_vec++;
      if (draw_if.draw_row !== 5'(e.row)) begin n_err++; $display("FAIL draw_row got=%0d want=%0d", draw_if.draw_row, e.row); end
    end
    if (exp_lvl >= 0) begin
      n_vec++;
      if (fifo_level !== 4'(exp_lvl)) begin n_err++; $display("FAIL pop_level got=%0d want=%0d", fifo_level, exp_lvl); end
    end
    draw_if.draw_done = 1'b1; @(negedge clk);
    draw_if.draw_done = 1'b0; @(negedge clk);
  endtask

  task automatic send(input logic [7:0] c);
    bit d;
    model_push(c, decrypt, d);
    type_char(c);
    if (d) serve(-1);
    else begin
      repeat (6) @(negedge clk);
      n_vec++;
      if (draw_if.draw_req !== 1'b0) begin n_err++; $display("FAIL no_draw c=%h draw_req=%b want 0", c, draw_if.draw_req); end
    end
  endtask

  task automatic key_write(input int a, input int v);
    @(negedge clk); key_wr = 1'b1; key_addr = 2'(a); key_val = 5'(v);
    @(negedge clk); key_wr = 1'b0;
    if (v <= 25) mk[a] = v;
  endtask

  task automatic do_reset();
    @(negedge clk); resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0; draw_if.draw_done = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1; model_reset();
    @(negedge clk);
    n_vec++; if (draw_if.draw_req !== 1'b0)   begin n_err++; $display("FAIL rst_req got=%b want 0", draw_if.draw_req); end
    n_vec++; if (draw_if.draw_char !== 8'h00) begin n_err++; $display("FAIL rst_char got=%h want 00", draw_if.draw_char); end
    n_vec++; if (draw_if.draw_col !== 6'd0)   begin n_err++; $display("FAIL rst_col got=%0d want 0", draw_if.draw_col); end
    n_vec++; if (draw_if.draw_row !== 5'd0)   begin n_err++; $display("FAIL rst_row got=%0d want 0", draw_if.draw_row); end
    n_vec++; if (fifo_level !== 4'd0)         begin n_err++; $display("FAIL rst_level got=%0d want 0", fifo_level); end
    n_vec++; if (overflow !== 1'b0)           begin n_err++; $display("FAIL rst_ovf got=%b want 0", overflow); end
    n_vec++; if (cipher_idx !== 2'd0)         begin n_err++; $display("FAIL rst_idx got=%0d want 0", cipher_idx); end
  endtask

  task automatic test_encrypt();
    bit d;
    decrypt = 1'b0;
    model_push(8'h41, 1'b0, d);
    @(negedge clk); kb_ascii = 8'h41; kb_ready = 1'b1;
    @(posedge clk);
    repeat (3) @(negedge clk);
    n_vec++; if (draw_if.draw_req !== 1'b0) begin n_err++; $display("FAIL latency_early draw_req=%b want 0", draw_if.draw_req); end
    kb_ready = 1'b0;
    @(negedge clk);
    n_vec++; if (draw_if.draw_req !== 1'b1) begin n_err++; $display("FAIL latency draw_req=%b want 1", draw_if.draw_req); end
    n_vec++; if (draw_if.draw_char !== 8'h44) begin n_err++; $display("FAIL enc_A got=%h want 44", draw_if.draw_char); end
    serve(-1);
    send(8'h7A);
    n_vec++; if (cipher_idx !== 2'd2) begin n_err++; $display("FAIL enc_idx got=%0d want 2", cipher_idx); end
  endtask

  task automatic test_decrypt();
    do_reset();
    decrypt = 1'b1;
    send(8'h44);
    send(8'h35);
    n_vec++; if (cipher_idx !== 2'd1) begin n_err++; $display("FAIL dec_nonletter_idx got=%0d want 1", cipher_idx); end
    send(8'h42);
    n_vec++; if (cipher_idx !== 2'd2) begin n_err++; $display("FAIL dec_idx got=%0d want 2", cipher_idx); end
    decrypt = 1'b0;
  endtask

  task automatic test_key_reject();
    bit d;
    key_write(2, 30);
    model_push(8'h41, 1'b0, d);
    type_char(8'h41);
    wait_req();
    n_vec++; if (draw_if.draw_char !== 8'h45) begin n_err++; $display("FAIL key_reject got=%h want 45", draw_if.draw_char); end
    serve(-1);
    key_write(3, 7);
    send(8'h61);
  endtask

  task automatic test_overflow();
    bit d;
    draw_if.draw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) model_push(8'(8'h41 + i), 1'b0, d);
      type_char(8'(8'h41 + i));
    end
    repeat (4) @(negedge clk);
    n_vec++; if (fifo_level !== 4'd8) begin n_err++; $display("FAIL full_level got=%0d want 8", fifo_level); end
    n_vec++; if (overflow !== 1'b1)   begin n_err++; $display("FAIL overflow got=%b want 1", overflow); end
    n_vec++; if (cipher_idx !== 2'(midx)) begin n_err++; $display("FAIL drop_idx got=%0d want %0d", cipher_idx, midx); end
    for (int k = 1; k <= 9; k++) serve(9 - k);
    repeat (8) @(negedge clk);
    n_vec++; if (draw_if.draw_req !== 1'b0) begin n_err++; $display("FAIL drained draw_req=%b want 0", draw_if.draw_req); end
  endtask

  task automatic test_reset_mid();
    bit d;
    for (int i = 0; i < 4; i++) begin
      model_push(8'h30 + 8'(i), 1'b0, d);
      type_char(8'h30 + 8'(i));
    end
    repeat (3) @(negedge clk);
    n_vec++; if (draw_if.draw_req !== 1'b1) begin n_err++; $display("FAIL pre_rst_req got=%b want 1", draw_if.draw_req); end
    n_vec++; if (fifo_level !== 4'd3) begin n_err++; $display("FAIL pre_rst_level got=%0d want 3", fifo_level); end
    resetn = 1'b0;
    #1;
    n_vec++; if (draw_if.draw_req !== 1'b0) begin n_err++; $display("FAIL async_drop got=%b want 0", draw_if.draw_req); end
    @(negedge clk); resetn = 1'b1; model_reset();
    repeat (6) @(negedge clk);
    n_vec++; if (fifo_level !== 4'd0) begin n_err++; $display("FAIL post_rst_level got=%0d want 0", fifo_level); end
    n_vec++; if (draw_if.draw_req !== 1'b0) begin n_err++; $display("FAIL post_rst_req got=%b want 0", draw_if.draw_req); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL post_rst_ovf got=%b want 0", overflow); end
    for (int i = 0; i < 4; i++) send(8'h61);
  endtask

  task automatic test_cursor();
    bit d;
    do_reset();
    decrypt = 1'b0;
    repeat (29) send(8'h0D);
    repeat (39) send(8'h2E);
    model_push(8'h78, 1'b0, d);
    type_char(8'h78);
    wait_req();
    n_vec++; if (draw_if.draw_col !== 6'd39 || draw_if.draw_row !== 5'd29) begin
      n_err++; $display("FAIL corner got=%0d/%0d want 39/29", draw_if.draw_col, draw_if.draw_row); end
    serve(-1);
    send(8'h2D);
    send(8'h0D); send(8'h0D);
    repeat (5) send(8'h2E);
    send(8'h0D);
    repeat (3) send(8'h2E);
    send(8'h08);
    send(8'h23);
    send(8'h0D);
    send(8'h08);
    send(8'h24);
  endtask

  task automatic test_random();
    int r;
    logic [7:0] c;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 5) == 0) key_write($urandom_range(0, 3), $urandom_range(0, 31));
      decrypt = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: c = 8'(8'h41 + $urandom_range(0, 25));
        3, 4, 5: c = 8'(8'h61 + $urandom_range(0, 25));
        6:       c = 8'(8'h30 + $urandom_range(0, 9));
        7:       c = 8'h20;
        8:       c = 8'h0D;
        default: c = 8'h08;
      endcase
      send(c);
    end
    n_vec++; if (cipher_idx !== 2'(midx)) begin n_err++; $display("FAIL rand_idx got=%0d want %0d", cipher_idx, midx); end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_key_reject();
    test_overflow();
    test_reset_mid();
    test_cursor();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
